// File: rtl/me_pe_pkg.sv
// me_pe_pkg: shared types, default sizes and the absolute-difference helper for the ME PE array.
package me_pe_pkg;
  typedef enum logic [1:0] {HOLD = 2'd0, UP1 = 2'd1, UP_LONG = 2'd2, DN1 = 2'd3} ref_op_e;
  localparam int PIXEL_D = 8;
  localparam int COLS_D = 32;
  localparam int ROWS_D = 32;
  localparam int NUM_CB_D = 2;
  localparam int SHIFT_LONG_D = 8;
  function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
    return a > b ? a - b : b - a;
  endfunction
endpackage

// File: rtl/me_pe_cell.sv
// me_pe_cell: one pixel of the PE array: reference register, current-block banks, |ref-curr| register.
module me_pe_cell import me_pe_pkg::*; #(
  parameter int PIXEL = PIXEL_D,
  parameter int NUM_CB = NUM_CB_D,
  localparam int CBW = $clog2(NUM_CB)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              ref_op,
  input  logic [PIXEL-1:0]        up1_d,
  input  logic [PIXEL-1:0]        long_d,
  input  logic [PIXEL-1:0]        dn_d,
  output logic [PIXEL-1:0]        ref_q,
  input  logic                    curr_we,
  input  logic [CBW-1:0]          curr_bank,
  input  logic [PIXEL-1:0]        curr_d,
  output logic [NUM_CB*PIXEL-1:0] curr_q,
  input  logic [CBW-1:0]          abs_sel,
  output logic [PIXEL-1:0]        abs_q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ref_q <= '0;
      curr_q <= '0;
      abs_q <= '0;
    end else begin
      ref_q <= ref_op == UP1 ? up1_d : ref_op == UP_LONG ? long_d : ref_op == DN1 ? dn_d : ref_q;
      if (curr_we) curr_q[curr_bank*PIXEL +: PIXEL] <= curr_d;
      abs_q <= PIXEL'(absdiff(32'(ref_q), 32'(curr_q[abs_sel*PIXEL +: PIXEL])));
    end
endmodule

// File: rtl/me_pe_array_param.sv
// me_pe_array_param: HEVC integer-ME PE array with banked current blocks and a sliding reference window.
// Define ME_ROW_SAD_EN to add registered per-row SAD outputs.
module me_pe_array_param import me_pe_pkg::*; #(
  parameter int PIXEL = PIXEL_D,
  parameter int COLS = COLS_D,
  parameter int ROWS = ROWS_D,
  parameter int NUM_CB = NUM_CB_D,
  parameter int SHIFT_LONG = SHIFT_LONG_D,
  localparam int CBW = $clog2(NUM_CB),
  localparam int SW = PIXEL + $clog2(COLS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          curr_valid,
  input  logic [COLS*PIXEL-1:0]         curr_row,
  input  logic [CBW-1:0]                curr_wr_bank,
  output logic                          curr_load_done,
  output logic                          curr_loading,
  input  logic [1:0]                    ref_op,
  input  logic [SHIFT_LONG*COLS*PIXEL-1:0] ref_rows,
  input  logic [CBW-1:0]                abs_bank_sel,
  output logic [ROWS*COLS*PIXEL-1:0]    abs_outs,
  output logic                          abs_valid
`ifdef ME_ROW_SAD_EN
  ,
  output logic [ROWS*SW-1:0]            row_sad,
  output logic                          row_sad_valid
`endif
);
  localparam int RW = $clog2(ROWS);
  logic [RW-1:0] row_cnt;
  logic [CBW-1:0] wr_bank, ld_bank;
  logic op_q;
  logic [PIXEL-1:0] ref_q [ROWS][COLS];
  logic [NUM_CB*PIXEL-1:0] curr_q [ROWS][COLS];
  assign curr_loading = row_cnt != '0;
  // the target bank is taken from the port only on the first row of a load
  assign ld_bank = curr_loading ? wr_bank : curr_wr_bank;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_cnt <= '0;
      wr_bank <= '0;
      curr_load_done <= 1'b0;
      op_q <= 1'b0;
      abs_valid <= 1'b0;
    end else begin
      if (curr_valid) begin
        row_cnt <= row_cnt == RW'(ROWS-1) ? '0 : row_cnt + 1'b1;
        wr_bank <= ld_bank;
      end
      curr_load_done <= curr_valid && row_cnt == RW'(ROWS-1);
      op_q <= ref_op != HOLD;
      abs_valid <= op_q && !(curr_loading && wr_bank == abs_bank_sel);
    end
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      localparam int RU = r < ROWS-1 ? r+1 : r;
      localparam int RD = r > 0 ? r-1 : 0;
      localparam int RL = r+SHIFT_LONG < ROWS ? r+SHIFT_LONG : r;
      localparam int K = r+SHIFT_LONG < ROWS ? 0 : r-(ROWS-SHIFT_LONG);
      logic [PIXEL-1:0] up1_d, long_d, dn_d, cd, aq;
      assign up1_d = r == ROWS-1 ? ref_rows[c*PIXEL +: PIXEL] : ref_q[RU][c];
      assign long_d = r+SHIFT_LONG < ROWS ? ref_q[RL][c] : ref_rows[(K*COLS+c)*PIXEL +: PIXEL];
      assign dn_d = r == 0 ? ref_rows[c*PIXEL +: PIXEL] : ref_q[RD][c];
      assign cd = r == ROWS-1 ? curr_row[c*PIXEL +: PIXEL] : curr_q[RU][c][ld_bank*PIXEL +: PIXEL];
      assign abs_outs[(r*COLS+c)*PIXEL +: PIXEL] = aq;
      me_pe_cell #(.PIXEL(PIXEL), .NUM_CB(NUM_CB)) u_cell (
        .clk(clk), .rst(rst), .ref_op(ref_op),
        .up1_d(up1_d), .long_d(long_d), .dn_d(dn_d), .ref_q(ref_q[r][c]),
        .curr_we(curr_valid), .curr_bank(ld_bank), .curr_d(cd), .curr_q(curr_q[r][c]),
        .abs_sel(abs_bank_sel), .abs_q(aq)
      );
    end
  end
`ifdef ME_ROW_SAD_EN
  logic [SW-1:0] row_sum [ROWS];
  always_comb
    for (int r = 0; r < ROWS; r++) begin
      row_sum[r] = '0;
      for (int c = 0; c < COLS; c++) row_sum[r] = row_sum[r] + SW'(abs_outs[(r*COLS+c)*PIXEL +: PIXEL]);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_sad <= '0;
      row_sad_valid <= 1'b0;
    end else begin
      for (int r = 0; r < ROWS; r++) row_sad[r*SW +: SW] <= row_sum[r];
      row_sad_valid <= abs_valid;
    end
`endif
endmodule

// File: tb/tb_me_pe_array_param.sv
// tb_me_pe_array_param: directed self-checking bench for the ME PE array (default build).
module tb_me_pe_array_param;
  import me_pe_pkg::*;
  localparam int P = 8, C = 32, R = 32, SL = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic curr_valid = 1'b0;
  logic [C*P-1:0] curr_row = '0;
  logic [0:0] curr_wr_bank = '0, abs_bank_sel = '0;
  logic curr_load_done, curr_loading, abs_valid;
  logic [1:0] ref_op = HOLD;
  logic [SL*C*P-1:0] ref_rows = '0;
  logic [R*C*P-1:0] abs_outs;
  int checks = 0, failures = 0, done_cnt = 0;
  logic [7:0] exp_row [R];

  me_pe_array_param dut (
    .clk(clk), .rst(rst), .curr_valid(curr_valid), .curr_row(curr_row),
    .curr_wr_bank(curr_wr_bank), .curr_load_done(curr_load_done), .curr_loading(curr_loading),
    .ref_op(ref_op), .ref_rows(ref_rows), .abs_bank_sel(abs_bank_sel),
    .abs_outs(abs_outs), .abs_valid(abs_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_abs(input string tag);
    for (int r = 0; r < R; r++)
      chk($sformatf("%s_row%0d", tag, r), abs_outs[r*C*P +: C*P], {C{exp_row[r]}});
  endtask

  // rows valued base+k; the bank port toggles after the first row to show it is ignored
  task automatic load(input logic [7:0] base, input logic [0:0] bank, input int n);
    for (int k = 0; k < n; k++) begin
      curr_valid = 1'b1;
      curr_row = {C{8'(base + 8'(k))}};
      curr_wr_bank = k == 0 ? bank : ~bank;
      tick();
      if (curr_load_done) done_cnt++;
    end
    curr_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_abs_zero", 256'(|abs_outs), 256'(0));
    chk("rst_abs_valid", 256'(abs_valid), 256'(0));
    chk("rst_done", 256'(curr_load_done), 256'(0));
    chk("rst_loading", 256'(curr_loading), 256'(0));
    rst = 1'b0;
    tick();
    done_cnt = 0;
    load(8'd0, 1'b0, 1);
    chk("loading_after_row1", 256'(curr_loading), 256'(1));
    load(8'd1, 1'b0, 31);
    chk("load0_done_cnt", 256'(done_cnt), 256'(1));
    chk("load0_done_now", 256'(curr_load_done), 256'(1));
    chk("load0_not_loading", 256'(curr_loading), 256'(0));
    tick();
    chk("load0_done_pulse_end", 256'(curr_load_done), 256'(0));
    for (int k = 0; k < R; k++) begin
      ref_op = UP1;
      ref_rows = '0;
      ref_rows[C*P-1:0] = {C{8'(100 + k)}};
      tick();
    end
    ref_op = HOLD;
    tick();
    chk("fill_valid", 256'(abs_valid), 256'(1));
    for (int r = 0; r < R; r++) exp_row[r] = 8'd100;
    chk_abs("fill");
    tick();
    chk("hold_valid_drop", 256'(abs_valid), 256'(0));
    ref_rows = '1;
    ref_op = UP_LONG;
    tick();
    ref_op = HOLD;
    tick();
    chk("long_valid", 256'(abs_valid), 256'(1));
    for (int r = 0; r < R; r++) exp_row[r] = r < R-SL ? 8'd108 : 8'(255 - r);
    chk_abs("long");
    ref_rows = '0;
    ref_rows[C*P-1:0] = {C{8'd50}};
    ref_op = DN1;
    tick();
    ref_op = UP1;
    tick();
    ref_op = HOLD;
    tick();
    chk("dnup_valid", 256'(abs_valid), 256'(1));
    exp_row[R-1] = 8'd19;
    chk_abs("dnup");
    abs_bank_sel = 1'b1;
    ref_op = UP1;
    ref_rows[C*P-1:0] = {C{8'd200}};
    for (int k = 0; k < R; k++) begin
      curr_valid = 1'b1;
      curr_row = {C{8'd5}};
      curr_wr_bank = k == 0 ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("busy_valid_%0d", k), 256'(abs_valid), 256'(0));
    end
    chk("load1_done", 256'(curr_load_done), 256'(1));
    curr_valid = 1'b0;
    tick();
    chk("load1_valid_back", 256'(abs_valid), 256'(1));
    for (int r = 0; r < R; r++) exp_row[r] = 8'd195;
    chk_abs("bank1");
    abs_bank_sel = 1'b0;
    for (int k = 0; k < R; k++) begin
      curr_valid = 1'b1;
      curr_row = {C{8'(7 + k)}};
      curr_wr_bank = k == 0 ? 1'b1 : 1'b0;
      tick();
      chk($sformatf("par_valid_%0d", k), 256'(abs_valid), 256'(1));
    end
    curr_valid = 1'b0;
    for (int r = 0; r < R; r++) exp_row[r] = 8'(200 - r);
    chk_abs("bank0_par");
    abs_bank_sel = 1'b1;
    ref_op = HOLD;
    tick();
    for (int r = 0; r < R; r++) exp_row[r] = 8'(193 - r);
    chk_abs("bank1_rows");
    done_cnt = 0;
    load(8'd40, 1'b0, 10);
    rst = 1'b1;
    #2;
    chk("midrst_abs_zero", 256'(|abs_outs), 256'(0));
    chk("midrst_loading", 256'(curr_loading), 256'(0));
    chk("midrst_done", 256'(curr_load_done), 256'(0));
    chk("midrst_valid", 256'(abs_valid), 256'(0));
    tick();
    rst = 1'b0;
    abs_bank_sel = 1'b0;
    tick();
    chk("midrst_no_done", 256'(curr_load_done), 256'(0));
    load(8'd0, 1'b0, R);
    chk("reload_done_cnt", 256'(done_cnt), 256'(1));
    tick();
    for (int r = 0; r < R; r++) exp_row[r] = 8'(r);
    chk_abs("reload");
    chk("reload_valid", 256'(abs_valid), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
